// File: rtl/barrel_dmg_ctrl.sv
// Barrel-vs-player collision detector with per-barrel edge hit pulses,
// and the lives / post-hit invulnerability / game-over state machine.
module barrel_dmg_ctrl #(
  parameter int unsigned BARRELS       = 5,
  parameter int unsigned XW            = 11,
  parameter int unsigned YW            = 11,
  parameter int unsigned BARREL_W      = 24,
  parameter int unsigned PLAYER_W      = 40,
  parameter int unsigned Y_OFFSET      = 64,
  parameter int unsigned Y_TOL         = 0,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 60
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic                        game_restart,
  input  logic [BARRELS-1:0]          barrel,
  input  logic [XW-1:0]               xpos_player,
  input  logic [YW-1:0]               ypos_player,
  input  logic [BARRELS-1:0][XW-1:0]  xpos,
  input  logic [BARRELS-1:0][YW-1:0]  ypos,
  output logic [BARRELS-1:0]          hit,
  output logic                        dmg,
  output logic [3:0]                  lives,
  output logic                        invuln,
  output logic                        game_over
);

  localparam int unsigned CW = $clog2(INVULN_FRAMES + 1);
  localparam logic [XW:0] BW_EXT = (XW + 1)'(BARREL_W);
  localparam logic [XW:0] PW_EXT = (XW + 1)'(PLAYER_W);
  localparam logic [YW:0] YOFF_EXT = (YW + 1)'(Y_OFFSET);
  localparam logic [YW:0] YTOL_EXT = (YW + 1)'(Y_TOL);
  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
  localparam logic [CW-1:0] CNT_INIT = CW'(INVULN_FRAMES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  state_t             state_q, state_d;
  logic [BARRELS-1:0] ov, ov_q, ov_d, hit_q, hit_d;
  logic [3:0]         lives_q, lives_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dmg_q, dmg_d, invuln_q, invuln_d, game_over_q, game_over_d;
  logic               new_hit;

  // One extra bit keeps the sums from wrapping at the right/bottom screen edge.
  function automatic logic strike(input logic [XW-1:0] bx, input logic [YW-1:0] by,
                                  input logic [XW-1:0] px, input logic [YW-1:0] py);
    logic [XW:0] bx_e, px_e;
    logic [YW:0] by_e, py_e, dy;
    bx_e = {1'b0, bx};
    px_e = {1'b0, px};
    by_e = {1'b0, by} + YOFF_EXT;
    py_e = {1'b0, py};
    dy = (by_e >= py_e) ? (by_e - py_e) : (py_e - by_e);
    return (bx_e + BW_EXT >= px_e) && (bx_e <= px_e + PW_EXT) && (dy <= YTOL_EXT);
  endfunction

  always_comb begin
    ov = '0;
    for (int i = 0; i < BARRELS; i++) begin
      ov[i] = barrel[i] & strike(xpos[i], ypos[i], xpos_player, ypos_player);
    end
  end

  assign new_hit = |(ov & ~ov_q);

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    dmg_d   = 1'b0;
    ov_d    = ov;
    hit_d   = ov & ~ov_q;
    if (game_restart) begin
      state_d = ALIVE;
      lives_d = LIVES_INIT;
      cnt_d   = '0;
      ov_d    = '0;
    end else begin
      case (state_q)
        ALIVE: begin
          if (new_hit) begin
            dmg_d   = 1'b1;
            lives_d = lives_q - 4'd1;
            if (lives_q == 4'd1) begin
              state_d = DEAD;
              cnt_d   = '0;
            end else begin
              state_d = INVULN;
              cnt_d   = CNT_INIT;
            end
          end
        end
        INVULN: begin
          // Strikes during invulnerability still pulse hit but never cost a life.
          if (frame_tick) begin
            if (cnt_q <= CNT_ONE) begin
              state_d = ALIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        DEAD: begin
          lives_d = 4'd0;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end
    invuln_d    = (state_d == INVULN);
    game_over_d = (state_d == DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALIVE;
      lives_q     <= LIVES_INIT;
      cnt_q       <= '0;
      ov_q        <= '0;
      hit_q       <= '0;
      dmg_q       <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      ov_q        <= ov_d;
      hit_q       <= hit_d;
      dmg_q       <= dmg_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign hit       = hit_q;
  assign dmg       = dmg_q;
  assign lives     = lives_q;
  assign invuln    = invuln_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_barrel_dmg_ctrl.sv
// Scoreboard bench for barrel_dmg_ctrl: stimulus queues expected output events,
// a monitor pops them whenever a pulse fires or the lives/invuln/game_over status moves.
module tb_barrel_dmg_ctrl;

  localparam int B = 5;

  typedef struct packed {
    logic [B-1:0] hit;
    logic         dmg;
    logic [3:0]   lives;
    logic         invuln;
    logic         game_over;
  } obs_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 frame_tick;
  logic                 game_restart;
  logic [B-1:0]         barrel;
  logic [10:0]          xpos_player;
  logic [10:0]          ypos_player;
  logic [B-1:0][10:0]   xpos;
  logic [B-1:0][10:0]   ypos;
  logic [B-1:0]         hit;
  logic                 dmg;
  logic [3:0]           lives;
  logic                 invuln;
  logic                 game_over;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [5:0] prev_status = 'x;

  barrel_dmg_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_restart(game_restart),
    .barrel(barrel), .xpos_player(xpos_player), .ypos_player(ypos_player),
    .xpos(xpos), .ypos(ypos), .hit(hit), .dmg(dmg), .lives(lives),
    .invuln(invuln), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Monitor: an output event is any hit/dmg pulse or any change of the status outputs.
  always @(negedge clk) begin
    obs_t cur, e;
    cur = '{hit: hit, dmg: dmg, lives: lives, invuln: invuln, game_over: game_over};
    if ((hit != '0) || dmg || ({lives, invuln, game_over} !== prev_status)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event t=%0t: got hit=%b dmg=%b lives=%0d invuln=%b go=%b, expected no event",
                 $time, hit, dmg, lives, invuln, game_over);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("[TB] FAIL event t=%0t: got hit=%b dmg=%b lives=%0d invuln=%b go=%b, expected hit=%b dmg=%b lives=%0d invuln=%b go=%b",
                   $time, cur.hit, cur.dmg, cur.lives, cur.invuln, cur.game_over,
                   e.hit, e.dmg, e.lives, e.invuln, e.game_over);
        end
      end
    end
    prev_status = {lives, invuln, game_over};
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [B-1:0] h, input logic d, input logic [3:0] l,
                               input logic iv, input logic go);
    exp_q.push_back('{hit: h, dmg: d, lives: l, invuln: iv, game_over: go});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic checkOutput();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_events: got %0d expected events never seen, required 0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; game_restart = 1'b0; barrel = '0;
    xpos_player = 11'd90; ypos_player = 11'd100;
    for (int i = 0; i < B; i++) begin
      xpos[i] = 11'd100;
      ypos[i] = 11'd36;
    end
    applyStimulus(5'b00000, 0, 4'd3, 0, 0);
    cyc(3);
    rst = 1'b0;
    cyc(2);

    $display("[TB] single strike on barrel 2, held overlap, invulnerability expiry");
    applyStimulus(5'b00100, 1, 4'd2, 1, 0);
    barrel = 5'b00100;
    cyc(200);
    ticks(59);
    cyc(5);
    applyStimulus(5'b00000, 0, 4'd2, 0, 0);
    ticks(1);
    cyc(10);
    barrel = '0;
    cyc(2);

    $display("[TB] simultaneous strike by barrels 0 and 1");
    applyStimulus(5'b00011, 1, 4'd1, 1, 0);
    barrel = 5'b00011;
    cyc(3);
    barrel = '0;
    applyStimulus(5'b00000, 0, 4'd1, 0, 0);
    ticks(60);
    cyc(2);

    $display("[TB] final strike, strike while dead, restart");
    applyStimulus(5'b01000, 1, 4'd0, 0, 1);
    barrel = 5'b01000;
    cyc(3);
    barrel = '0;
    cyc(2);
    applyStimulus(5'b10000, 0, 4'd0, 0, 1);
    barrel = 5'b10000;
    cyc(3);
    barrel = '0;
    ticks(3);
    applyStimulus(5'b00000, 0, 4'd3, 0, 0);
    game_restart = 1'b1;
    cyc(1);
    game_restart = 1'b0;
    cyc(3);

    $display("[TB] restart coinciding with a strike, then reset mid-invulnerability");
    applyStimulus(5'b00001, 0, 4'd3, 0, 0);
    applyStimulus(5'b00001, 1, 4'd2, 1, 0);
    barrel = 5'b00001;
    game_restart = 1'b1;
    cyc(1);
    game_restart = 1'b0;
    cyc(3);
    barrel = '0;
    ticks(30);
    applyStimulus(5'b00000, 0, 4'd3, 0, 0);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("[TB] screen-edge, inactive barrel and vertical tolerance cases");
    xpos_player = 11'd0;
    xpos[0] = 11'd2030;
    barrel = 5'b00001;
    cyc(3);
    barrel = '0;
    xpos_player = 11'd20;
    xpos[1] = 11'd0;
    cyc(3);
    xpos[0] = 11'd0;
    ypos[0] = 11'd37;
    barrel = 5'b00001;
    cyc(3);
    applyStimulus(5'b00001, 1, 4'd2, 1, 0);
    ypos[0] = 11'd36;
    cyc(5);

    checkOutput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
